// File: rtl/mmio_uart_buffer_if.sv
// Bus bundle between the core's I/O data-memory port, the UART byte streams
// and mmio_uart_buffer.
interface mmio_uart_buffer_if;
  logic        io_sel;
  logic        io_load;
  logic [3:0]  wea;
  logic [4:0]  adr;
  logic [31:0] din;
  logic [31:0] dout;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  modport master (
    output io_sel, io_load, wea, adr, din, tx_ready, rx_data, rx_valid,
    input  dout, tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  io_sel, io_load, wea, adr, din, tx_ready, rx_data, rx_valid,
    output dout, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/mmio_uart_buffer.sv
// Memory-mapped UART buffer: TX/RX byte FIFOs, status word and cycle counter,
// with load data returned one cycle after the address, like data memory.
module mmio_uart_buffer #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input logic              clk,
  input logic              rst,
  mmio_uart_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [PW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic          ovf;
  logic [31:0]   cyc;
  logic [31:0]   rd_data_p1;
  logic [31:0]   status;

  logic store, load, ctrl_wr;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push_req, tx_push, tx_pop, rx_push, rx_pop;
  logic unused_bits;

  // A load that carries any write enable is a store only.
  assign store    = bus.io_sel && (|bus.wea);
  assign load     = bus.io_sel && bus.io_load && !store;
  assign ctrl_wr  = store && (bus.adr == 5'd5);

  assign tx_full  = (tx_cnt == CW'(DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == CW'(DEPTH));
  assign rx_empty = (rx_cnt == '0);

  assign tx_push_req = store && (bus.adr == 5'd2);
  assign tx_push     = tx_push_req && !tx_full;
  assign tx_pop      = !tx_empty && bus.tx_ready;
  assign rx_push     = bus.rx_valid && !rx_full;
  assign rx_pop      = load && (bus.adr == 5'd1) && !rx_empty;

  assign bus.tx_valid = !tx_empty;
  assign bus.tx_data  = tx_mem[tx_rd];
  assign bus.rx_ready = !rx_full;
  assign bus.dout     = rd_data_p1;

  assign unused_bits = ^bus.din[31:8];

  always_comb begin
    status           = '0;
    status[0]        = !tx_full;
    status[1]        = !rx_empty;
    status[2]        = ovf;
    status[8 +: CW]  = tx_cnt;
    status[16 +: CW] = rx_cnt;
  end

  // FIFO storage carries no reset; only pointers and counts define contents.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= bus.din[7:0];
    if (rx_push) rx_mem[rx_wr] <= bus.rx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
      ovf    <= 1'b0;
      cyc    <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + PW'(1);
      if (tx_pop)  tx_rd <= tx_rd + PW'(1);
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);

      if (rx_push) rx_wr <= rx_wr + PW'(1);
      if (rx_pop)  rx_rd <= rx_rd + PW'(1);
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);

      if (ctrl_wr)                    ovf <= 1'b0;
      else if (tx_push_req && tx_full) ovf <= 1'b1;

      // Clear wins over the free-running increment.
      cyc <= ctrl_wr ? 32'd0 : cyc + 32'd1;
    end
  end

  // Load stage: address sampled here, data valid after this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_p1 <= '0;
    end else if (load) begin
      case (bus.adr)
        5'd0:    rd_data_p1 <= status;
        5'd1:    rd_data_p1 <= rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rd]};
        5'd4:    rd_data_p1 <= cyc;
        default: rd_data_p1 <= 32'd0;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_buffer.sv
// Directed bench for mmio_uart_buffer: FIFO fill/drain, overflow, counter
// clear and asynchronous reset, against hand-computed values.
module tb_mmio_uart_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [31:0] rd;

  mmio_uart_buffer_if bus ();

  mmio_uart_buffer #(.DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.io_sel  = 1'b0;
    bus.io_load = 1'b0;
    bus.wea     = 4'h0;
    bus.adr     = 5'd0;
    bus.din     = 32'd0;
  endtask

  task automatic load(input logic [4:0] a, output logic [31:0] d);
    bus.io_sel  = 1'b1;
    bus.io_load = 1'b1;
    bus.wea     = 4'h0;
    bus.adr     = a;
    tick();
    idle();
    d = bus.dout;
  endtask

  task automatic store(input logic [4:0] a, input logic [31:0] v);
    bus.io_sel  = 1'b1;
    bus.io_load = 1'b0;
    bus.wea     = 4'hF;
    bus.adr     = a;
    bus.din     = v;
    tick();
    idle();
  endtask

  initial begin
    idle();
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset state
    #3;
    check("rst_dout", bus.dout, 32'd0);
    check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
    #9 rst = 1'b1;
    tick();
    load(5'd0, rd);
    check("status_after_reset", rd, 32'h0000_0001);

    // TX fill to full plus one dropped byte
    for (int i = 0; i < 9; i++) store(5'd2, 32'h41 + i);
    load(5'd0, rd);
    check("status_tx_full_ovf", rd, 32'h0000_0804);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("tx_valid_drain", {31'd0, bus.tx_valid}, 32'd1);
      check("tx_data_drain", {24'd0, bus.tx_data}, 32'h41 + i);
      tick();
    end
    check("tx_valid_empty", {31'd0, bus.tx_valid}, 32'd0);
    bus.tx_ready = 1'b0;

    // RX fill, offer a ninth byte while full
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.rx_data = 8'h10 + 8'(i);
      check("rx_ready_filling", {31'd0, bus.rx_ready}, 32'd1);
      tick();
    end
    check("rx_ready_full", {31'd0, bus.rx_ready}, 32'd0);
    bus.rx_data = 8'h99;
    tick();
    bus.rx_valid = 1'b0;
    load(5'd0, rd);
    check("status_rx_full", rd, 32'h0008_0007);
    for (int i = 0; i < 8; i++) begin
      load(5'd1, rd);
      check("rx_pop_data", rd, 32'h10 + i);
    end
    load(5'd1, rd);
    check("rx_pop_empty", rd, 32'd0);
    load(5'd0, rd);
    check("status_rx_empty", rd, 32'h0000_0005);

    // Simultaneous CPU push and UART pop at count 3
    for (int i = 0; i < 3; i++) store(5'd2, 32'h51 + i);
    bus.io_sel   = 1'b1;
    bus.wea      = 4'hF;
    bus.adr      = 5'd2;
    bus.din      = 32'h55;
    bus.tx_ready = 1'b1;
    tick();
    idle();
    bus.tx_ready = 1'b0;
    load(5'd0, rd);
    check("status_push_pop", rd, 32'h0000_0305);
    bus.tx_ready = 1'b1;
    check("tx_pp_0", {24'd0, bus.tx_data}, 32'h52);
    tick();
    check("tx_pp_1", {24'd0, bus.tx_data}, 32'h53);
    tick();
    check("tx_pp_2", {24'd0, bus.tx_data}, 32'h55);
    tick();
    check("tx_pp_empty", {31'd0, bus.tx_valid}, 32'd0);
    bus.tx_ready = 1'b0;

    // Counter clear, then 10 cycles
    store(5'd5, 32'hDEAD_BEEF);
    for (int i = 0; i < 10; i++) tick();
    load(5'd4, rd);
    check("cycle_count", rd, 32'd10);
    load(5'd7, rd);
    check("unmapped_load", rd, 32'd0);
    load(5'd0, rd);
    check("status_ovf_cleared", rd, 32'h0000_0001);

    // Asynchronous reset with both FIFOs at count 5
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.rx_data = 8'h20 + 8'(i);
      store(5'd2, 32'h60 + i);
    end
    bus.rx_valid = 1'b0;
    load(5'd0, rd);
    check("status_before_reset", rd, 32'h0005_0503);
    #3 rst = 1'b0;
    #1;
    check("async_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("async_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
    check("async_dout", bus.dout, 32'd0);
    #2 rst = 1'b1;
    tick();
    load(5'd0, rd);
    check("status_after_async", rd, 32'h0000_0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
